// File: rtl/toy_bus_ack_pkg.sv
// Shared ack-network widths and packed payload type, common to the arbiter,
// pipe slice and decoder nodes.
package toy_bus_ack_pkg;

    localparam int OPCODE_W   = 1;
    localparam int DATA_W     = 256;
    localparam int SIDEBAND_W = 32;
    localparam int ID_W       = 4;
    localparam int ACK_PLD_W  = OPCODE_W + DATA_W + SIDEBAND_W + 2 * ID_W;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [DATA_W-1:0]     data;
        logic [SIDEBAND_W-1:0] sideband;
        logic [ID_W-1:0]       src_id;
        logic [ID_W-1:0]       tgt_id;
    } ack_pld_t;

    function automatic ack_pld_t pack_ack(
        input logic [OPCODE_W-1:0]   opcode,
        input logic [DATA_W-1:0]     data,
        input logic [SIDEBAND_W-1:0] sideband,
        input logic [ID_W-1:0]       src_id,
        input logic [ID_W-1:0]       tgt_id
    );
        ack_pld_t p;
        p.opcode   = opcode;
        p.data     = data;
        p.sideband = sideband;
        p.src_id   = src_id;
        p.tgt_id   = tgt_id;
        return p;
    endfunction

endpackage

// File: rtl/toy_bus_CmnFifoMem.sv
// DEPTH x W register-array storage: synchronous write, combinational read.
// Entries reset to zero so the head payload is defined out of reset.
module toy_bus_CmnFifoMem #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [DEPTH-1:0][W-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/toy_bus_dpipe_ack_slice.sv
// Registered FIFO slice after an ack arbiter node; cuts the vld/rdy and payload
// timing path. Optional stall counter under TOY_BUS_ACK_PIPE_PERF_EN.
module toy_bus_dpipe_ack_slice
    import toy_bus_ack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in0_vld,
    output logic                  in0_rdy,
    input  logic [OPCODE_W-1:0]   in0_opcode,
    input  logic [DATA_W-1:0]     in0_data,
    input  logic [SIDEBAND_W-1:0] in0_sideband,
    input  logic [ID_W-1:0]       in0_src_id,
    input  logic [ID_W-1:0]       in0_tgt_id,
    output logic                  out0_vld,
    input  logic                  out0_rdy,
    output logic [OPCODE_W-1:0]   out0_opcode,
    output logic [DATA_W-1:0]     out0_data,
    output logic [SIDEBAND_W-1:0] out0_sideband,
    output logic [ID_W-1:0]       out0_src_id,
    output logic [ID_W-1:0]       out0_tgt_id
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    ack_pld_t      wr_pld, rd_pld;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Flags come only from registers, so out0_rdy never reaches in0_rdy.
    assign in0_rdy  = ~full;
    assign out0_vld = ~empty;
    assign push     = in0_vld && ~full;
    assign pop      = ~empty && out0_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign wr_pld = pack_ack(in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id);

    toy_bus_CmnFifoMem #(
        .DEPTH (DEPTH),
        .W     (ACK_PLD_W),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_pld),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_pld)
    );

    assign out0_opcode   = rd_pld.opcode;
    assign out0_data     = rd_pld.data;
    assign out0_sideband = rd_pld.sideband;
    assign out0_src_id   = rd_pld.src_id;
    assign out0_tgt_id   = rd_pld.tgt_id;

`ifdef TOY_BUS_ACK_PIPE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out0_vld && !out0_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_toy_bus_dpipe_ack_slice.sv
// Self-checking bench: hand sequences, a fill/backpressure vector table and a
// queue-based reference model under random vld/rdy traffic.
module tb_toy_bus_dpipe_ack_slice;
    import toy_bus_ack_pkg::*;

    localparam int DEPTH = 2;
    localparam int N_RAND = 10000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in0_vld;
    logic                  in0_rdy;
    logic [OPCODE_W-1:0]   in0_opcode;
    logic [DATA_W-1:0]     in0_data;
    logic [SIDEBAND_W-1:0] in0_sideband;
    logic [ID_W-1:0]       in0_src_id;
    logic [ID_W-1:0]       in0_tgt_id;
    logic                  out0_vld;
    logic                  out0_rdy;
    logic [OPCODE_W-1:0]   out0_opcode;
    logic [DATA_W-1:0]     out0_data;
    logic [SIDEBAND_W-1:0] out0_sideband;
    logic [ID_W-1:0]       out0_src_id;
    logic [ID_W-1:0]       out0_tgt_id;
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
    logic [31:0]           stall_cnt;
`endif

    always #5 clk = ~clk;

    toy_bus_dpipe_ack_slice #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in0_vld       (in0_vld),
        .in0_rdy       (in0_rdy),
        .in0_opcode    (in0_opcode),
        .in0_data      (in0_data),
        .in0_sideband  (in0_sideband),
        .in0_src_id    (in0_src_id),
        .in0_tgt_id    (in0_tgt_id),
        .out0_vld      (out0_vld),
        .out0_rdy      (out0_rdy),
        .out0_opcode   (out0_opcode),
        .out0_data     (out0_data),
        .out0_sideband (out0_sideband),
        .out0_src_id   (out0_src_id),
        .out0_tgt_id   (out0_tgt_id)
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    ack_pld_t    q[$];
    int unsigned model_stall;
    int          n_popped;

    function automatic ack_pld_t out_pld();
        return {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id};
    endfunction

    function automatic ack_pld_t in_pld();
        return {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};
    endfunction

    function automatic ack_pld_t tag_pld(input logic [7:0] tag);
        logic [DATA_W-1:0] d;
        d = {32{tag}};
        return {1'b1, d, {4{tag}}, tag[3:0], ~tag[3:0]};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkp(input string name, input ack_pld_t act, input ack_pld_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input ack_pld_t p, input logic v, input logic r);
        in0_vld = v;
        {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id} = p;
        out0_rdy = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        q.delete();
        model_stall = 0;
        n_popped = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock against the reference model: compare at negedge, update the
    // queue at posedge from whatever handshakes the rules allow.
    task automatic model_cycle(input string name, output logic pushed);
        logic     do_push, do_pop;
        ack_pld_t p;
        @(negedge clk);
        chk1({name, ".in_rdy"}, in0_rdy, q.size() < DEPTH);
        chk1({name, ".out_vld"}, out0_vld, q.size() > 0);
        if (q.size() > 0) chkp({name, ".pld"}, out_pld(), q[0]);
        do_push = in0_vld && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && out0_rdy;
        if ((q.size() > 0) && !out0_rdy) model_stall++;
        p = in_pld();
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
            n_popped++;
        end
        if (do_push) q.push_back(p);
        pushed = do_push;
        #1;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] tag;
        logic       rdy;
        logic       exp_in_rdy;
        logic       exp_out_vld;
        logic [7:0] exp_tag;
    } vec_t;

    vec_t vecs[9];

    initial begin
        ack_pld_t p0;
        logic     pushed;
        int       sent, cyc;

        // fill, backpressure, full-with-pop, drain
        vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[2] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        // reset state, checked while reset is still asserted
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        #12;
        chk1("reset.in_rdy", in0_rdy, 1'b1);
        chk1("reset.out_vld", out0_vld, 1'b0);
        chkp("reset.pld", out_pld(), '0);
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
        chk32("reset.stall_cnt", stall_cnt, 32'd0);
`endif
        do_reset();

        // single beat
        p0 = pack_ack(1'b1, {32{8'hA5}}, 32'h1234_5678, 4'd3, 4'd7);
        drive(p0, 1'b1, 1'b1);
        @(negedge clk);
        chk1("single.vld_before", out0_vld, 1'b0);
        @(posedge clk); #1;
        drive('0, 1'b0, 1'b1);
        @(negedge clk);
        chk1("single.vld", out0_vld, 1'b1);
        chkp("single.pld", out_pld(), p0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("single.vld_after", out0_vld, 1'b0);

        // vector table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tag_pld(vecs[i].tag), vecs[i].vld, vecs[i].rdy);
            @(negedge clk);
            chk1($sformatf("vec%0d.in_rdy", i), in0_rdy, vecs[i].exp_in_rdy);
            chk1($sformatf("vec%0d.out_vld", i), out0_vld, vecs[i].exp_out_vld);
            if (vecs[i].exp_out_vld)
                chkp($sformatf("vec%0d.pld", i), out_pld(), tag_pld(vecs[i].exp_tag));
            @(posedge clk); #1;
        end

        // streaming: one beat per cycle after one cycle of latency
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            drive(tag_pld(8'(i)), i < 100, 1'b1);
            @(negedge clk);
            if (i < 100) chk1($sformatf("stream%0d.in_rdy", i), in0_rdy, 1'b1);
            if (i > 0) begin
                chk1($sformatf("stream%0d.vld", i), out0_vld, 1'b1);
                chkp($sformatf("stream%0d.pld", i), out_pld(), tag_pld(8'(i - 1)));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("stream.drained", out0_vld, 1'b0);
        @(posedge clk); #1;

        // randomized traffic against the queue model
        do_reset();
        sent = 0;
        cyc  = 0;
        while ((n_popped < N_RAND) && (cyc < 60000)) begin
            drive(pack_ack(1'($urandom), {$urandom, $urandom, $urandom, $urandom,
                                          $urandom, $urandom, $urandom, 32'(sent)},
                           $urandom, 4'($urandom_range(0, 3)), 4'($urandom)),
                  (sent < N_RAND) && ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3) != 0);
            model_cycle("rand", pushed);
            if (pushed) sent++;
            cyc++;
        end
        chk32("rand.received", 32'(n_popped), 32'(N_RAND));
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
        chk32("rand.stall_cnt", stall_cnt, model_stall);
`endif

        // asynchronous reset with two entries held
        do_reset();
        drive(tag_pld(8'h11), 1'b1, 1'b0);
        model_cycle("hold0", pushed);
        drive(tag_pld(8'h22), 1'b1, 1'b0);
        model_cycle("hold1", pushed);
        drive('0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("hold.full", in0_rdy, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst.out_vld", out0_vld, 1'b0);
        chk1("arst.in_rdy", in0_rdy, 1'b1);
        chkp("arst.pld", out_pld(), '0);
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
        chk32("arst.stall_cnt", stall_cnt, 32'd0);
`endif
        q.delete();
        model_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // five stall cycles on a single beat
        drive(tag_pld(8'h33), 1'b1, 1'b0);
        model_cycle("stall.push", pushed);
        drive('0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) model_cycle($sformatf("stall%0d", i), pushed);
        drive('0, 1'b0, 1'b1);
        model_cycle("stall.pop", pushed);
`ifdef TOY_BUS_ACK_PIPE_PERF_EN
        chk32("stall.cnt", stall_cnt, 32'd5);
`endif
        model_cycle("stall.empty", pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
